// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite-sheet geometry, loader state encoding and region helpers
package sprite_pkg;

   localparam int SHEET_W_DEF = 600;
   localparam int SHEET_H_DEF = 250;
   localparam int ADDR_W_DEF  = 18;
   localparam int CRD_W       = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_RECV,
      ST_WR_LO,
      ST_WR_HI,
      ST_DONE
   } state_t;

   // One axis of a region fits when it is non-empty and origin+extent stays inside the sheet.
   function automatic logic region_fits(input logic [CRD_W-1:0] org, input logic [CRD_W-1:0] ext,
                                        input int limit);
      logic [CRD_W:0] stop;
      stop = {1'b0, org} + {1'b0, ext};
      return (ext != '0) && (stop <= (CRD_W+1)'(limit));
   endfunction

endpackage

// File: rtl/region_addr_gen.sv
// rtl/region_addr_gen.sv - walks a rectangular region row-major, producing frameRAM addresses
module region_addr_gen
   import sprite_pkg::*;
#(
   parameter int SHEET_W = SHEET_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [CRD_W-1:0]  x_i,
   input  logic [CRD_W-1:0]  y_i,
   input  logic [CRD_W-1:0]  w_i,
   input  logic [CRD_W-1:0]  h_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(SHEET_W);

   logic [CRD_W-1:0]  col_q;
   logic [CRD_W-1:0]  row_q;
   logic [ADDR_W-1:0] row_base_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] start_addr;
   logic              col_end;
   logic              row_end;

   // The only multiply: the region origin, computed once at load time.
   assign start_addr = ADDR_W'(y_i) * PITCH + ADDR_W'(x_i);
   assign col_end    = (col_q == (w_i - 10'd1));
   assign row_end    = (row_q == (h_i - 10'd1));
   assign last_o     = col_end && row_end;
   assign addr_o     = addr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
      end else if (load_i) begin
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= start_addr;
         addr_q     <= start_addr;
      end else if (step_i) begin
         if (col_end) begin
            col_q      <= '0;
            row_q      <= row_q + 10'd1;
            row_base_q <= row_base_q + PITCH;
            addr_q     <= row_base_q + PITCH;
         end else begin
            col_q  <= col_q + 10'd1;
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - streams packed 4-bit palette bytes into a rectangular frameRAM region
module sprite_loader
   import sprite_pkg::*;
#(
   parameter int SHEET_W = SHEET_W_DEF,
   parameter int SHEET_H = SHEET_H_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [9:0]        RegX,
   input  logic [9:0]        RegY,
   input  logic [9:0]        RegW,
   input  logic [9:0]        RegH,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] write_address,
   output logic [3:0]        data_In,
   output logic              we,
   output logic              Busy,
   output logic              Done,
   output logic              Err
);

   state_t           state_q;
   logic [CRD_W-1:0] x_q, y_q, w_q, h_q;
   logic [7:0]       byte_q;
   logic [3:0]       data_q;
   logic             we_q, in_ready_q, busy_q, done_q, err_q;
   logic             region_ok;
   logic             gen_load, gen_step, last_pix;

   assign region_ok = region_fits(x_q, w_q, SHEET_W) && region_fits(y_q, h_q, SHEET_H);
   assign gen_load  = (state_q == ST_CHECK) && region_ok;
   assign gen_step  = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);

   region_addr_gen #(
      .SHEET_W (SHEET_W),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .load_i (gen_load),
      .step_i (gen_step),
      .x_i    (x_q),
      .y_i    (y_q),
      .w_i    (w_q),
      .h_i    (h_q),
      .addr_o (write_address),
      .last_o (last_pix)
   );

   assign in_ready = in_ready_q;
   assign data_In  = data_q;
   assign we       = we_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Err      = err_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         w_q        <= '0;
         h_q        <= '0;
         byte_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  x_q     <= RegX;
                  y_q     <= RegY;
                  w_q     <= RegW;
                  h_q     <= RegH;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (region_ok) begin
                  in_ready_q <= 1'b1;
                  state_q    <= ST_RECV;
               end else begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_RECV: begin
               if (in_valid) begin
                  byte_q     <= in_data;
                  data_q     <= in_data[3:0];
                  we_q       <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_WR_LO;
               end
            end
            ST_WR_LO: begin
               // An odd pixel count ends here and the high nibble is never written.
               if (last_pix) begin
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  data_q  <= byte_q[7:4];
                  state_q <= ST_WR_HI;
               end
            end
            ST_WR_HI: begin
               we_q <= 1'b0;
               if (last_pix) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= ST_RECV;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               we_q       <= 1'b0;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - directed scoreboard bench for sprite_loader
module tb_sprite_loader;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [9:0]  RegX = '0, RegY = '0, RegW = '0, RegH = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic [17:0] write_address;
   logic [3:0]  data_In;
   logic        we, Busy, Done, Err;

   typedef struct packed {
      logic [17:0] addr;
      logic [3:0]  data;
   } wr_t;

   wr_t        sb[$];
   logic [7:0] src[$];
   int tests = 0, fails = 0;
   int wr_cnt = 0, done_cnt = 0, ir_cnt = 0, busy_cyc = 0;

   sprite_loader dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Start         (Start),
      .RegX          (RegX),
      .RegY          (RegY),
      .RegW          (RegW),
      .RegH          (RegH),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .write_address (write_address),
      .data_In       (data_In),
      .we            (we),
      .Busy          (Busy),
      .Done          (Done),
      .Err           (Err)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (!Reset) begin
         if (we) begin
            wr_cnt++;
            tests++;
            assert (sb.size() != 0)
            else begin
               fails++;
               $error("FAIL unexpected_write: got addr %0d data %0h, required no write", write_address, data_In);
            end
            if (sb.size() != 0) begin
               wr_t exp;
               exp = sb.pop_front();
               tests++;
               assert ({write_address, data_In} === exp)
               else begin
                  fails++;
                  $error("FAIL write: got (%0d,%0h) required (%0d,%0h)", write_address, data_In, exp.addr, exp.data);
               end
            end
         end
         if (Done)     done_cnt++;
         if (in_ready) ir_cnt++;
         if (Busy)     busy_cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic run_load(input int x, input int y, input int w, input int h, input int gap_pct,
                           input bit noise, input int abort_after, input int exp_busy);
      int npix, nbytes, idx, cyc, d0, ir0, w0;
      bit ok, acc;
      ok     = (w != 0) && (h != 0) && (x + w <= 600) && (y + h <= 250);
      npix   = ok ? w * h : 0;
      nbytes = (npix + 1) / 2;
      while (src.size() < nbytes) src.push_back(8'($urandom));
      for (int i = 0; i < npix; i++) begin
         wr_t e;
         e.addr = 18'((y + i / w) * 600 + x + i % w);
         e.data = (i % 2 == 1) ? src[i / 2][7:4] : src[i / 2][3:0];
         sb.push_back(e);
      end
      d0 = done_cnt; ir0 = ir_cnt; w0 = wr_cnt;
      @(negedge Clk); #1;
      RegX = 10'(x); RegY = 10'(y); RegW = 10'(w); RegH = 10'(h);
      Start = 1'b1;
      busy_cyc = 0;
      @(negedge Clk); #1;
      Start = 1'b0;
      idx = 0; cyc = 0;
      while (idx < nbytes && cyc < 20000) begin
         if (abort_after > 0 && (wr_cnt - w0) >= abort_after) break;
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = src[idx];
         if (noise) begin
            Start = ($urandom_range(3) == 0);
            RegX = 10'($urandom); RegY = 10'($urandom); RegW = 10'($urandom); RegH = 10'($urandom);
         end
         acc = in_valid && in_ready;
         @(negedge Clk); #1;
         cyc++;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      Start    = 1'b0;
      src.delete();
      check("load_timeout", 32'(cyc < 20000), 32'd1);
      if (abort_after > 0) return;
      cyc = 0;
      while (Busy && cyc < 50) begin
         @(negedge Clk); #1;
         cyc++;
      end
      check("busy_drop", 32'(Busy), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("err", 32'(Err), 32'(!ok));
      if (exp_busy > 0) check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
      if (!ok) check("no_ready", 32'(ir_cnt - ir0), 32'd0);
      sb.delete();
   endtask

   initial begin
      #2 Reset = 1'b1;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_err", 32'(Err), 32'd0);
      check("rst_addr", 32'(write_address), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;

      src = '{8'h21, 8'h43, 8'h65};
      run_load(100, 150, 3, 2, 0, 1'b0, 0, 11);

      src = '{8'hBA, 8'hDC};
      run_load(5, 5, 3, 1, 0, 1'b0, 0, 7);

      run_load(590, 0, 20, 1, 0, 1'b0, 0, 2);
      run_load(0, 0, 0, 4, 0, 1'b0, 0, 2);
      run_load(0, 249, 1, 2, 0, 1'b0, 0, 2);

      run_load(590, 249, 10, 1, 0, 1'b0, 0, 17);
      run_load(0, 0, 600, 2, 0, 1'b0, 0, 1802);
      run_load(37, 10, 7, 5, 40, 1'b1, 0, 0);
      run_load(3, 100, 6, 9, 60, 1'b1, 0, 0);

      run_load(0, 0, 600, 250, 0, 1'b0, 10, 0);
      @(posedge Clk); #2;
      Reset = 1'b1;
      #1;
      check("abort_remaining", 32'(sb.size()), 32'd149990);
      check("abort_we", 32'(we), 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_addr", 32'(write_address), 32'd0);
      sb.delete();
      @(negedge Clk);
      Reset = 1'b0;
      src = '{8'h21, 8'h43, 8'h65};
      run_load(100, 150, 3, 2, 0, 1'b0, 0, 11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
